// File: rtl/uart_image_loader_if.sv
// Pixel write port plus frame handshake between the UART image loader and its consumer.
// The loader is the master; the image buffer / inference FSM is the slave.
interface uart_image_loader_if #(
   parameter int ADDR_W = 10
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              frame_valid;
   logic              frame_ack;
   logic              loading;
   logic              overrun;
   logic [7:0]        frame_err_cnt;

   modport master (
      output wr_en, wr_addr, wr_data, frame_valid, loading, overrun, frame_err_cnt,
      input  frame_ack
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, frame_valid, loading, overrun, frame_err_cnt,
      output frame_ack
   );
endinterface

// File: rtl/uart_image_loader.sv
// 8N1 UART receiver feeding a sync-byte framed loader that writes one image into a pixel buffer.
// The loader holds frame_valid until the consumer acknowledges the frame.
module uart_image_loader #(
   parameter int         CLKS_PER_BIT = 434,
   parameter int         NUM_PIXELS   = 784,
   parameter int         ADDR_W       = 10,
   parameter logic [7:0] SYNC_BYTE    = 8'hAA
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                rx_serial,
   uart_image_loader_if.master bus
);
   localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
   typedef enum logic [1:0] {LD_WAIT_SYNC, LD_LOAD, LD_READY} ld_state_t;

   logic [1:0]        sync_reg;
   logic              rx_bit;
   rx_state_t         rx_state_reg;
   logic [CNT_W-1:0]  clk_cnt_reg;
   logic [2:0]        bit_idx_reg;
   logic [7:0]        shift_reg;
   logic              byte_valid_reg;
   logic              frame_err_reg;

   ld_state_t         ld_state_reg;
   logic [ADDR_W-1:0] count_reg;
   logic              last_reg;
   logic              wr_en_reg;
   logic [ADDR_W-1:0] wr_addr_reg;
   logic [7:0]        wr_data_reg;
   logic              frame_valid_reg;
   logic              overrun_reg;
   logic [7:0]        err_cnt_reg;

   // Presetting to 1 keeps a reset release from looking like a start bit.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_reg <= 2'b11;
      end else begin
         sync_reg <= {sync_reg[0], rx_serial};
      end
   end

   assign rx_bit = sync_reg[1];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_state_reg   <= RX_IDLE;
         clk_cnt_reg    <= '0;
         bit_idx_reg    <= '0;
         shift_reg      <= '0;
         byte_valid_reg <= 1'b0;
         frame_err_reg  <= 1'b0;
      end else begin
         byte_valid_reg <= 1'b0;
         frame_err_reg  <= 1'b0;
         case (rx_state_reg)
            RX_IDLE: begin
               clk_cnt_reg <= '0;
               if (!rx_bit) rx_state_reg <= RX_START;
            end
            RX_START: begin
               if (clk_cnt_reg == HALF_LAST) begin
                  clk_cnt_reg  <= '0;
                  bit_idx_reg  <= '0;
                  rx_state_reg <= rx_bit ? RX_IDLE : RX_DATA;
               end else begin
                  clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
               end
            end
            RX_DATA: begin
               if (clk_cnt_reg == BIT_LAST) begin
                  clk_cnt_reg <= '0;
                  shift_reg   <= {rx_bit, shift_reg[7:1]};
                  if (bit_idx_reg == 3'd7) rx_state_reg <= RX_STOP;
                  else                     bit_idx_reg  <= bit_idx_reg + 3'd1;
               end else begin
                  clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
               end
            end
            RX_STOP: begin
               if (clk_cnt_reg == BIT_LAST) begin
                  clk_cnt_reg <= '0;
                  if (rx_bit) begin
                     byte_valid_reg <= 1'b1;
                     rx_state_reg   <= RX_IDLE;
                  end else begin
                     frame_err_reg <= 1'b1;
                     rx_state_reg  <= RX_BREAK;
                  end
               end else begin
                  clk_cnt_reg <= clk_cnt_reg + CNT_W'(1);
               end
            end
            RX_BREAK: begin
               if (rx_bit) rx_state_reg <= RX_IDLE;
            end
            default: rx_state_reg <= RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ld_state_reg    <= LD_WAIT_SYNC;
         count_reg       <= '0;
         last_reg        <= 1'b0;
         wr_en_reg       <= 1'b0;
         wr_addr_reg     <= '0;
         wr_data_reg     <= '0;
         frame_valid_reg <= 1'b0;
         overrun_reg     <= 1'b0;
         err_cnt_reg     <= '0;
      end else begin
         wr_en_reg <= 1'b0;
         if (frame_err_reg && err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
         case (ld_state_reg)
            LD_WAIT_SYNC: begin
               if (byte_valid_reg && shift_reg == SYNC_BYTE) begin
                  count_reg    <= '0;
                  ld_state_reg <= LD_LOAD;
               end
            end
            LD_LOAD: begin
               // last_reg delays READY by one cycle so frame_valid follows the final write.
               if (last_reg) begin
                  last_reg        <= 1'b0;
                  frame_valid_reg <= 1'b1;
                  ld_state_reg    <= LD_READY;
               end else if (frame_err_reg) begin
                  count_reg    <= '0;
                  ld_state_reg <= LD_WAIT_SYNC;
               end else if (byte_valid_reg) begin
                  wr_en_reg   <= 1'b1;
                  wr_addr_reg <= count_reg;
                  wr_data_reg <= shift_reg;
                  count_reg   <= count_reg + ADDR_W'(1);
                  if (count_reg == LAST_ADDR) last_reg <= 1'b1;
               end
            end
            LD_READY: begin
               if (bus.frame_ack) begin
                  frame_valid_reg <= 1'b0;
                  overrun_reg     <= 1'b0;
                  ld_state_reg    <= LD_WAIT_SYNC;
               end else if (byte_valid_reg) begin
                  overrun_reg <= 1'b1;
               end
            end
            default: ld_state_reg <= LD_WAIT_SYNC;
         endcase
      end
   end

   assign bus.wr_en         = wr_en_reg;
   assign bus.wr_addr       = wr_addr_reg;
   assign bus.wr_data       = wr_data_reg;
   assign bus.frame_valid   = frame_valid_reg;
   assign bus.loading       = (ld_state_reg == LD_LOAD);
   assign bus.overrun       = overrun_reg;
   assign bus.frame_err_cnt = err_cnt_reg;
endmodule

// File: tb/tb_uart_image_loader.sv
// Directed bench: a small 4-pixel loader driven from a vector table plus corner sequences,
// and a 784-pixel loader fed one full frame at a fast bit rate.
module tb_uart_image_loader;
   localparam int CPB_S = 8;
   localparam int NP_S  = 4;
   localparam int AW_S  = 2;
   localparam int CPB_B = 4;
   localparam int NP_B  = 784;
   localparam int AW_B  = 10;

   logic clk = 1'b0;
   logic resetn;
   logic rx_s;
   logic rx_b;

   always #5 clk = ~clk;

   uart_image_loader_if #(.ADDR_W(AW_S)) bus_s ();
   uart_image_loader_if #(.ADDR_W(AW_B)) bus_b ();

   uart_image_loader #(.CLKS_PER_BIT(CPB_S), .NUM_PIXELS(NP_S), .ADDR_W(AW_S), .SYNC_BYTE(8'hAA)) dut_s (
      .clk       (clk),
      .resetn    (resetn),
      .rx_serial (rx_s),
      .bus       (bus_s.master)
   );

   uart_image_loader #(.CLKS_PER_BIT(CPB_B), .NUM_PIXELS(NP_B), .ADDR_W(AW_B), .SYNC_BYTE(8'hAA)) dut_b (
      .clk       (clk),
      .resetn    (resetn),
      .rx_serial (rx_b),
      .bus       (bus_b.master)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Write monitor: samples on the falling edge, away from the DUT's active edge.
   int              cyc = 0;
   int              wr_cnt_s = 0;
   int              last_wr_cyc_s = 0;
   int              fv_rise_cyc_s = 0;
   logic            fv_prev_s = 1'b0;
   logic [AW_S-1:0] last_addr_s = '0;
   logic [7:0]      last_data_s = '0;
   int              wr_cnt_b = 0;
   int              bad_b = 0;
   logic [AW_B-1:0] last_addr_b = '0;
   logic [7:0]      last_data_b = '0;

   always @(negedge clk) begin
      cyc++;
      if (bus_s.wr_en) begin
         wr_cnt_s++;
         last_wr_cyc_s = cyc;
         last_addr_s   = bus_s.wr_addr;
         last_data_s   = bus_s.wr_data;
      end
      if (bus_s.frame_valid && !fv_prev_s) fv_rise_cyc_s = cyc;
      fv_prev_s = bus_s.frame_valid;
      if (bus_b.wr_en) begin
         if (int'(bus_b.wr_addr) != wr_cnt_b || bus_b.wr_data != (wr_cnt_b[7:0] ^ 8'h3C)) bad_b++;
         wr_cnt_b++;
         last_addr_b = bus_b.wr_addr;
         last_data_b = bus_b.wr_data;
      end
   end

   task automatic send(input bit big, input logic [7:0] d, input bit stop_ok);
      logic [9:0] fr;
      int         cpb;
      fr  = {stop_ok, d, 1'b0};
      cpb = big ? CPB_B : CPB_S;
      for (int i = 0; i < 10; i++) begin
         if (big) rx_b = fr[i];
         else     rx_s = fr[i];
         repeat (cpb) @(negedge clk);
      end
      if (big) rx_b = 1'b1;
      else     rx_s = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic ack_frame(input string tag);
      bus_s.frame_ack = 1'b1;
      @(negedge clk);
      bus_s.frame_ack = 1'b0;
      check({tag, "_ack_fv"},   bus_s.frame_valid, 0);
      check({tag, "_ack_ovr"},  bus_s.overrun, 0);
      check({tag, "_ack_load"}, bus_s.loading, 0);
      $display("ack %s fv=%0b ovr=%0b", tag, bus_s.frame_valid, bus_s.overrun);
   endtask

   typedef struct {
      logic [7:0] d;
      bit         stop_ok;
      int         exp_w;
      int         exp_addr;
      logic [7:0] exp_data;
      bit         exp_fv;
      bit         exp_ovr;
      bit         exp_load;
      int         exp_err;
   } vec_t;

   vec_t vt [17];

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      int e0;
      logic [9:0] fr;

      vt[0]  = '{8'hAA, 1'b1, 0, 0, 8'h00, 1'b0, 1'b0, 1'b1, 0};
      vt[1]  = '{8'h01, 1'b1, 1, 0, 8'h01, 1'b0, 1'b0, 1'b1, 0};
      vt[2]  = '{8'h02, 1'b1, 1, 1, 8'h02, 1'b0, 1'b0, 1'b1, 0};
      vt[3]  = '{8'h03, 1'b1, 1, 2, 8'h03, 1'b0, 1'b0, 1'b1, 0};
      vt[4]  = '{8'h04, 1'b1, 1, 3, 8'h04, 1'b1, 1'b0, 1'b0, 0};
      vt[5]  = '{8'h99, 1'b1, 0, 0, 8'h00, 1'b1, 1'b1, 1'b0, 0};
      vt[6]  = '{8'h55, 1'b1, 0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 0};
      vt[7]  = '{8'h12, 1'b1, 0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 0};
      vt[8]  = '{8'hAA, 1'b1, 0, 0, 8'h00, 1'b0, 1'b0, 1'b1, 0};
      vt[9]  = '{8'h10, 1'b1, 1, 0, 8'h10, 1'b0, 1'b0, 1'b1, 0};
      vt[10] = '{8'h20, 1'b1, 1, 1, 8'h20, 1'b0, 1'b0, 1'b1, 0};
      vt[11] = '{8'h30, 1'b1, 1, 2, 8'h30, 1'b0, 1'b0, 1'b1, 0};
      vt[12] = '{8'h40, 1'b1, 1, 3, 8'h40, 1'b1, 1'b0, 1'b0, 0};
      vt[13] = '{8'hAA, 1'b1, 0, 0, 8'h00, 1'b0, 1'b0, 1'b1, 0};
      vt[14] = '{8'h01, 1'b1, 1, 0, 8'h01, 1'b0, 1'b0, 1'b1, 0};
      vt[15] = '{8'h5A, 1'b0, 0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1};
      vt[16] = '{8'h02, 1'b1, 0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1};

      resetn = 1'b0;
      rx_s = 1'b1;
      rx_b = 1'b1;
      bus_s.frame_ack = 1'b0;
      bus_b.frame_ack = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_wr_en", bus_s.wr_en, 0);
      check("rst_addr",  bus_s.wr_addr, 0);
      check("rst_data",  bus_s.wr_data, 0);
      check("rst_fv",    bus_s.frame_valid, 0);
      check("rst_load",  bus_s.loading, 0);
      check("rst_ovr",   bus_s.overrun, 0);
      check("rst_err",   bus_s.frame_err_cnt, 0);
      check("rst_fv_b",  bus_b.frame_valid, 0);
      resetn = 1'b1;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 17; i++) begin
         w0 = wr_cnt_s;
         send(1'b0, vt[i].d, vt[i].stop_ok);
         check($sformatf("v%0d_wr", i), wr_cnt_s - w0, vt[i].exp_w);
         if (vt[i].exp_w != 0) begin
            check($sformatf("v%0d_addr", i), last_addr_s, vt[i].exp_addr);
            check($sformatf("v%0d_data", i), last_data_s, vt[i].exp_data);
         end
         check($sformatf("v%0d_fv", i),   bus_s.frame_valid, vt[i].exp_fv);
         check($sformatf("v%0d_ovr", i),  bus_s.overrun, vt[i].exp_ovr);
         check($sformatf("v%0d_load", i), bus_s.loading, vt[i].exp_load);
         check($sformatf("v%0d_err", i),  bus_s.frame_err_cnt, vt[i].exp_err);
         $display("vec %0d byte=%02h stop=%0b writes=%0d fv=%0b ovr=%0b load=%0b err=%0d",
                  i, vt[i].d, vt[i].stop_ok, wr_cnt_s - w0, bus_s.frame_valid,
                  bus_s.overrun, bus_s.loading, bus_s.frame_err_cnt);
         if (i == 4 || i == 12) check($sformatf("v%0d_fv_lag", i), fv_rise_cyc_s - last_wr_cyc_s, 1);
         if (i == 5)  ack_frame("f1");
         if (i == 12) ack_frame("f2");
      end

      // Short low glitch in LOAD must not be taken as a start bit.
      send(1'b0, 8'hAA, 1'b1);
      w0 = wr_cnt_s;
      e0 = int'(bus_s.frame_err_cnt);
      rx_s = 1'b0;
      repeat (2) @(negedge clk);
      rx_s = 1'b1;
      repeat (100) @(negedge clk);
      check("glitch_wr",  wr_cnt_s - w0, 0);
      check("glitch_err", bus_s.frame_err_cnt, e0);
      check("glitch_load", bus_s.loading, 1);
      send(1'b0, 8'h01, 1'b1);
      check("glitch_next_addr", last_addr_s, 0);
      check("glitch_next_data", last_data_s, 8'h01);
      $display("glitch writes=%0d err=%0d addr=%0d", wr_cnt_s - w0, bus_s.frame_err_cnt, last_addr_s);

      // Reset in the middle of a byte while loading.
      fr = {1'b1, 8'h33, 1'b0};
      for (int i = 0; i < 4; i++) begin
         rx_s = fr[i];
         repeat (CPB_S) @(negedge clk);
      end
      resetn = 1'b0;
      #1;
      check("mrst_wr_en", bus_s.wr_en, 0);
      check("mrst_addr",  bus_s.wr_addr, 0);
      check("mrst_data",  bus_s.wr_data, 0);
      check("mrst_fv",    bus_s.frame_valid, 0);
      check("mrst_load",  bus_s.loading, 0);
      check("mrst_ovr",   bus_s.overrun, 0);
      check("mrst_err",   bus_s.frame_err_cnt, 0);
      $display("midreset data=%02h err=%0d load=%0b", bus_s.wr_data, bus_s.frame_err_cnt, bus_s.loading);
      rx_s = 1'b1;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      repeat (20) @(negedge clk);
      w0 = wr_cnt_s;
      send(1'b0, 8'hAA, 1'b1);
      send(1'b0, 8'h07, 1'b1);
      check("mrst_next_wr",   wr_cnt_s - w0, 1);
      check("mrst_next_addr", last_addr_s, 0);
      check("mrst_next_data", last_data_s, 8'h07);
      $display("after reset writes=%0d addr=%0d data=%02h", wr_cnt_s - w0, last_addr_s, last_data_s);

      // Framing-error counter saturation; the first error also aborts the frame.
      for (int i = 0; i < 256; i++) begin
         send(1'b0, 8'h00, 1'b0);
         if (i == 0) begin
            check("ferr_abort_load", bus_s.loading, 0);
            check("ferr_first_cnt", bus_s.frame_err_cnt, 1);
         end
         if (i == 254) check("ferr_255", bus_s.frame_err_cnt, 255);
      end
      check("ferr_sat", bus_s.frame_err_cnt, 255);
      check("ferr_fv", bus_s.frame_valid, 0);
      $display("framing errors sent=256 cnt=%0d", bus_s.frame_err_cnt);

      // Full 784-pixel frame on the wide instance.
      send(1'b1, 8'hAA, 1'b1);
      check("big_load", bus_b.loading, 1);
      for (int i = 0; i < NP_B; i++) begin
         send(1'b1, 8'(i) ^ 8'h3C, 1'b1);
      end
      check("big_wr_cnt", wr_cnt_b, NP_B);
      check("big_bad",    bad_b, 0);
      check("big_last_addr", last_addr_b, 783);
      check("big_last_data", last_data_b, 8'h33);
      check("big_fv",   bus_b.frame_valid, 1);
      check("big_load_end", bus_b.loading, 0);
      $display("big frame writes=%0d last_addr=%0d last_data=%02h fv=%0b",
               wr_cnt_b, last_addr_b, last_data_b, bus_b.frame_valid);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_image_loader.md
Name: uart_image_loader

Overview:
- Upstream stage of neural_network: receives a 28x28 8-bit image over UART (8N1) on rx_serial.
- Frames the byte stream with a sync byte and writes pixels sequentially into the image buffer through a simple write port.
- Raises frame_valid when a complete image is in memory; holds it until the inference FSM acknowledges with frame_ack.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200). Must be >= 4.
- NUM_PIXELS, 784, pixels per frame.
- ADDR_W, 10, width of the write address and pixel count; 2^ADDR_W >= NUM_PIXELS.
- SYNC_BYTE, 8'hAA, start-of-frame marker.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- rx_serial  input  1  asynchronous UART line, idle high.
- frame_ack  input  1  one-cycle pulse from consumer: frame consumed.
- wr_en  output  1  one-cycle pixel write strobe.
- wr_addr  output  ADDR_W  pixel address, 0..NUM_PIXELS-1.
- wr_data  output  8  pixel value.
- frame_valid  output  1  complete frame resident in memory.
- loading  output  1  high while in LOAD.
- overrun  output  1  sticky: byte arrived while frame_valid was high.
- frame_err_cnt  output  8  saturating count of stop-bit errors.

Behaviour:
- Reset (async, resetn=0):
  - All outputs 0; wr_addr 0; pixel count 0.
  - Synchronizer flops preset to 1.
  - Both FSMs return to their idle states. A mid-frame reset discards the partial frame.
- rx_serial passes through a 2-flop synchronizer; all sampling uses the synchronized value.
- RX FSM:
  - IDLE -> START on a sampled 0.
  - START: wait CLKS_PER_BIT/2 cycles, then re-sample. If 1 (glitch), return to IDLE. If 0, go to DATA.
  - DATA: sample 8 bits, each CLKS_PER_BIT cycles apart at bit centre, LSB first.
  - STOP: after CLKS_PER_BIT cycles, sample. If 1, pulse byte_valid internally for one cycle. If 0, the byte is discarded, a framing error is flagged, and the FSM waits for the line to return to 1 before IDLE.
  - After a good stop sample, return to IDLE immediately so back-to-back bytes are accepted.
- Loader FSM (states WAIT_SYNC, LOAD, READY):
  - WAIT_SYNC: a byte equal to SYNC_BYTE clears the count and enters LOAD. All other bytes are ignored.
  - LOAD:
    - Each byte produces wr_en=1 for exactly one cycle, in the cycle after byte_valid.
    - In that cycle, wr_addr = current count and wr_data = byte; the count increments.
    - A byte equal to SYNC_BYTE inside LOAD is pixel data, not a resync.
    - The write with count = NUM_PIXELS-1 is the last one. frame_valid rises on the following cycle and the state becomes READY.
  - READY:
    - frame_valid held high.
    - Incoming bytes are dropped with no write and set overrun.
    - frame_ack: frame_valid and overrun clear next cycle; state returns to WAIT_SYNC.
    - A byte arriving in the same cycle as frame_ack is discarded and does not set overrun.
  - frame_ack outside READY is ignored.
  - Framing error in any state: frame_err_cnt increments, saturating at 255. A framing error in LOAD aborts the frame: return to WAIT_SYNC, count cleared, no frame_valid. Bytes already written stay in memory and are overwritten by the next frame.
- loading = (state == LOAD).
- wr_addr and wr_data hold their last values when wr_en=0.
- Throughput: one pixel per UART byte time. Full 784-pixel frame is about 68 ms at 115200 baud.

Test Plan (CLKS_PER_BIT=8, NUM_PIXELS=4 unless stated):
- Send AA,01,02,03,04 -> four wr_en pulses with addr 0..3 and data 01..04; frame_valid rises 1 cycle after the addr-3 write; loading 1 during bytes 2-5 then 0.
- Send 55,12,AA,10,20,30,40 -> 55 and 12 ignored (no wr_en); writes 10,20,30,40 at addr 0..3; frame_valid=1.
- Frame complete, then send 99 -> no wr_en, overrun=1. Pulse frame_ack -> frame_valid=0 and overrun=0 next cycle. Next AA,.. frame loads at addr 0.
- Send AA,01, then a byte with stop bit 0, then 02 -> frame_err_cnt=1; only addr 0 written; 02 ignored (WAIT_SYNC); frame_valid stays 0.
- 2-cycle low glitch on idle line -> no byte, no write, error count unchanged. Deassert resetn mid-byte of a LOAD -> all outputs 0 and state WAIT_SYNC; next AA frame loads from addr 0.
- 256 consecutive framing errors -> frame_err_cnt saturates at 255. Default parameters with a full 784-byte frame -> last write at addr 783 and frame_valid high.
